nibble_serial_adder: RTL and testbench
======================================

Name: nibble_serial_adder

Overview:
- Multi-cycle WIDTH-bit adder/subtractor that processes one 4-bit nibble per clock through a single 4-bit carry-lookahead nibble stage.
- Carry is registered between nibbles, from LSB nibble to MSB nibble.
- Sits upstream of result consumers and downstream of operand producers, joined to both by valid/ready handshakes.
- Trades latency (WIDTH/4 cycles) for one nibble adder's area.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be a multiple of 4 and ≥4; any other value is an elaboration error.
- NIB (localparam), WIDTH/4, number of nibble cycles per operation.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operands valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in (add mode only)
- sub  input  1  1 = compute A−B, 0 = compute A+B+cin
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result
- cout  output  1  carry out of bit WIDTH−1 (in sub mode, 1 = no borrow)
- overflow  output  1  two's-complement signed overflow
- busy  output  1  operation in progress (state RUN)

Behaviour:
- One clock domain. Reset is synchronous and active-high; it is sampled only on the rising edge of clk.
- Reset values:
  - state=IDLE, nibble index=0, carry register=0
  - out_valid=0, sum=0, cout=0, overflow=0, busy=0
  - in_ready=1 from the first cycle after reset
- in_ready is combinational: it equals (state==IDLE). Reset has priority over every other event.
- States and transitions:
  - IDLE: in_valid && in_ready at an edge → latch a, b', c0; idx=0; go to RUN. Otherwise stay.
  - RUN: each cycle processes nibble idx:
    - sum[4*idx+3:4*idx] ← S
    - carry reg ← c4
    - idx ← idx+1
    - When idx==NIB−1: cout ← c4, overflow ← c3 XOR c4 (carries into and out of bit WIDTH−1), then go to DONE.
  - DONE: out_valid=1. out_valid && out_ready at an edge → IDLE, out_valid=0. Otherwise hold.
- Operand preparation at accept:
  - sub=0: b'=b, c0=cin.
  - sub=1: b'=~b, c0=1; cin is ignored.
- Nibble stage, per bit i=0..3 of the current nibble:
  - p_i = a_i XOR b'_i, g_i = a_i AND b'_i
  - c_{i+1} = g_i | (p_i & c_i)
  - S_i = p_i XOR c_i
  - c0 of the nibble is the carry register (c0 from accept for idx 0).
- Latency: accept edge E → out_valid high in the cycle after edge E+NIB (4 cycles for WIDTH=16). Throughput is one result per NIB+2 cycles minimum.
- sum holds partial nibbles during RUN. sum, cout and overflow are only meaningful while out_valid=1.
- Inputs a, b, cin and sub are sampled only at the accept edge. Changes during RUN or DONE have no effect.
- in_valid during RUN or DONE is not accepted (in_ready=0). The upstream block must hold its operands.
- While out_valid=1 and out_ready=0, sum, cout and overflow are stable.
- reset during RUN or DONE aborts the operation: next cycle all outputs take their reset values, in_ready=1, and no partial result is emitted.
- No overlap: a new operation cannot be accepted in the same cycle a result is consumed. in_ready rises the cycle after the out handshake.

Test Plan:
1. Reset, then a=0x1234, b=0x4321, cin=0, sub=0 → sum=0x5555, cout=0, overflow=0. out_valid rises exactly 4 cycles after the accept edge; busy=1 for those 4 cycles.
2. a=0xFFFF, b=0x0001, sub=0 → sum=0x0000, cout=1, overflow=0 (carry ripples through all 4 nibbles). Also a=0x000F, b=0x0000, cin=1 → sum=0x0010, cout=0.
3. a=0x7FFF, b=0x0001, sub=0 → sum=0x8000, cout=0, overflow=1.
4. sub=1:
   - a=0x0005, b=0x0007, cin=1 → sum=0xFFFE, cout=0, overflow=0 (cin ignored).
   - a=0x8000, b=0x0001 → sum=0x7FFF, cout=1, overflow=1.
5. Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands → sum, cout and overflow stay stable and in_ready=0. Raise out_ready → out_valid drops next cycle and in_ready=1. The new operands are then accepted and produce the correct result.
6. Assert reset for one cycle during RUN idx=2 → next cycle out_valid=0, sum=0, busy=0, in_ready=1. A following 0x0001+0x0001 gives sum=0x0002 with normal latency.

Source files
------------

// File: rtl/nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder
//
// Multi-cycle WIDTH-bit adder/subtractor. One 4-bit carry-lookahead nibble
// stage is reused once per clock. The carry is held in a register between
// nibbles, moving from the LSB nibble up to the MSB nibble. An operation
// takes WIDTH/4 cycles. Operands arrive and results leave through
// valid/ready handshakes.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   operands valid
//   in_ready   block can accept operands (combinational, state == IDLE)
//   a, b       WIDTH-bit operands
//   cin        carry-in (add mode only)
//   sub        1 = A-B, 0 = A+B+cin
//   out_valid  result valid
//   out_ready  consumer accepts result
//   sum        WIDTH-bit result
//   cout       carry out of bit WIDTH-1 (in sub mode, 1 = no borrow)
//   overflow   two's-complement signed overflow
//   busy       operation in progress (state RUN)
// -----------------------------------------------------------------------------
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             busy
);

    localparam int NIB   = WIDTH / 4;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
        $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;   // already inverted in sub mode

    assign in_ready = (state == IDLE);

    // -------------------------------------------------------------------------
    // Operand capture. The registers are loaded at the accept edge. They are
    // read only in RUN, so their contents while idle do not matter.
    // NOTE: the datapath operand registers take no reset. That keeps the
    // reset fan-out on the control state only.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            a_reg <= a;
            b_reg <= sub ? ~b : b;
        end
    end

    // -------------------------------------------------------------------------
    // Nibble stage: 4-bit carry-lookahead. All carries come straight from
    // p/g and the registered carry-in, so the carry does not ripple.
    // -------------------------------------------------------------------------
    logic [3:0] a_nib, b_nib, p, g, nib_s;
    logic       c0, c1, c2, c3, c4;

    assign a_nib = a_reg[{idx, 2'b00} +: 4];
    assign b_nib = b_reg[{idx, 2'b00} +: 4];
    assign p     = a_nib ^ b_nib;
    assign g     = a_nib & b_nib;
    assign c0    = carry;

    assign c1 = g[0] | (p[0] & c0);
    assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c0);
    assign c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c0);

    assign nib_s = p ^ {c3, c2, c1, c0};

    // -------------------------------------------------------------------------
    // Control FSM with registered outputs. Reset overrides everything, so a
    // reset during RUN or DONE drops the operation without emitting a result.
    // NOTE: every state register here uses non-blocking assignment. All the
    // registers then update together from values taken before the edge.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            carry     <= 1'b0;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            overflow  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state <= RUN;
                        idx   <= '0;
                        carry <= sub ? 1'b1 : cin;   // +1 completes ~b in sub mode
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    sum[{idx, 2'b00} +: 4] <= nib_s;
                    carry                  <= c4;
                    idx                    <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        // c3/c4 are the carries into and out of bit WIDTH-1
                        cout      <= c4;
                        overflow  <= c3 ^ c4;
                        idx       <= '0;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_nibble_serial_adder
//
// Directed-vector bench for nibble_serial_adder (WIDTH = 16). Each vector has
// an expected value worked out by hand. Outputs are sampled 1 ns after the
// rising edge, and inputs are driven at that same point.
// -----------------------------------------------------------------------------
module tb_nibble_serial_adder;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;
    logic             busy;

    int errors = 0;
    int checks = 0;

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive operands with in_valid, then wait through the accept edge.
    task automatic start(input logic [15:0] ta, input logic [15:0] tb_,
                         input logic tcin, input logic tsub);
        a        = ta;
        b        = tb_;
        cin      = tcin;
        sub      = tsub;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        // Operands change after accept. The result must not be affected.
        a   = ~ta;
        b   = ~tb_;
        cin = ~tcin;
        sub = ~tsub;
    endtask

    // Wait for out_valid, then check latency, busy duration and in_ready.
    task automatic wait_done(input string tag);
        int lat      = 0;
        int busy_cnt = 0;
        int rdy_cnt  = 0;
        while (!out_valid && lat < 20) begin
            if (busy)     busy_cnt++;
            if (in_ready) rdy_cnt++;
            tick();
            lat++;
        end
        check({tag, "_latency"}, lat, 4);
        check({tag, "_busy_cycles"}, busy_cnt, 4);
        check({tag, "_in_ready_in_run"}, rdy_cnt, 0);
    endtask

    task automatic check_result(input string tag, input logic [15:0] es,
                                input logic ec, input logic eo);
        check({tag, "_sum"}, sum, es);
        check({tag, "_cout"}, cout, ec);
        check({tag, "_overflow"}, overflow, eo);
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_out_valid_drop"}, out_valid, 0);
        check({tag, "_in_ready_back"}, in_ready, 1);
    endtask

    task automatic run_op(input string tag, input logic [15:0] ta,
                          input logic [15:0] tb_, input logic tcin,
                          input logic tsub, input logic [15:0] es,
                          input logic ec, input logic eo);
        start(ta, tb_, tcin, tsub);
        wait_done(tag);
        check_result(tag, es, ec, eo);
        consume(tag);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_overflow", overflow, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);

        // Basic add, carry ripple, cin, signed overflow
        run_op("add_basic", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        run_op("add_ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("add_cin", 16'h000F, 16'h0000, 1'b1, 1'b0, 16'h0010, 1'b0, 1'b0);
        run_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);

        // Subtract: cin ignored; borrow and signed overflow
        run_op("sub_neg", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_op("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        // Backpressure: hold the result while new operands wait upstream
        start(16'h1111, 16'h2222, 1'b0, 1'b0);
        wait_done("bp_first");
        a        = 16'hAAAA;
        b        = 16'h5555;
        cin      = 1'b1;
        sub      = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_out_valid", out_valid, 1);
            check("bp_hold_sum", sum, 16'h3333);
            check("bp_hold_cout", cout, 0);
            check("bp_hold_overflow", overflow, 0);
            check("bp_hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_out_valid_drop", out_valid, 0);
        check("bp_in_ready_back", in_ready, 1);
        // AAAA + 5555 + 1 = 0x10000
        run_op("bp_second", 16'hAAAA, 16'h5555, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);

        // Abort: reset while RUN is at idx 2 (two nibbles written)
        start(16'h1234, 16'h4321, 1'b0, 1'b0);
        tick();
        tick();
        check("abort_busy_before", busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_out_valid", out_valid, 0);
        check("abort_sum", sum, 0);
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 1);
        run_op("after_abort", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
